// File: rtl/sincos_pkg.sv
// Shared defaults and helpers for the quarter-wave sine/cosine lookup.
package sincos_pkg;

   localparam int PW_DEFAULT = 12;
   localparam int DW_DEFAULT = 14;

   // Per-channel quadrant decision: mirror the quarter-wave address, negate the result.
   typedef struct packed {
      logic mirror;
      logic negate;
   } fold_t;

   function automatic int qaw_of(input int pw);
      return pw - 2;
   endfunction

   function automatic fold_t fold(input logic [1:0] q);
      fold_t f;
      f.mirror = q[0];
      f.negate = q[1];
      return f;
   endfunction

endpackage

// File: rtl/sc_qrom.sv
// Dual-port synchronous quarter-wave sine magnitude ROM; entry k samples the
// quarter wave at (k+0.5) so no entry is zero and none reaches full scale + 1.
module sc_qrom #(
   parameter int AW = 10,
   parameter int MW = 13
) (
   input  logic          clk,
   input  logic [AW-1:0] addr [2],
   output logic [MW-1:0] data [2]
);

   localparam real HALF_PI = 1.5707963267948966;

   function automatic logic [MW-1:0] entry(input int k);
      real amp;
      real x;
      amp = real'((1 << MW) - 1);
      x   = amp * $sin(HALF_PI * (real'(k) + 0.5) / real'(1 << AW));
      return MW'($rtoi(x + 0.5));
   endfunction

   // Contents are generated at elaboration; the table is constant.
   logic [MW-1:0] rom [2**AW];

   for (genvar gi = 0; gi < 2**AW; gi++) begin : g_rom
      assign rom[gi] = entry(gi);
   end

   always_ff @(posedge clk) begin
      data[0] <= rom[addr[0]];
      data[1] <= rom[addr[1]];
   end

endmodule

// File: rtl/sincos_qlut.sv
// Pipelined sine/cosine generator: direct phase lookup or NCO accumulator,
// quadrant fold into a shared quarter-wave ROM, 4-cycle fixed latency.
module sincos_qlut
   import sincos_pkg::*;
#(
   parameter int PW = PW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [PW-1:0]        phase,
   input  logic                 mode,
   input  logic                 acc_clr,
   output logic                 out_valid,
   output logic signed [DW-1:0] sin,
   output logic signed [DW-1:0] cos
);

   localparam int QAW = qaw_of(PW);
   localparam int MW  = DW - 1;

   logic [PW-1:0] acc_reg;
   logic [PW-1:0] acc_base;
   logic [PW-1:0] acc_next;
   logic [PW-1:0] p_next;
   logic [PW-1:0] p_reg;
   logic [3:0]    vld_reg;

   logic [QAW-1:0]       rom_addr [2];
   logic [MW-1:0]        rom_data [2];
   logic signed [DW-1:0] res [2];

   // Clear wins over the old accumulator value, so a same-cycle beat sees p=0.
   always_comb begin
      acc_base = acc_clr ? '0 : acc_reg;
      p_next   = mode ? acc_base : phase;
      acc_next = acc_base;
      if (in_valid && mode)
         acc_next = acc_base + phase;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg <= '0;
         vld_reg <= '0;
      end else begin
         acc_reg <= acc_next;
         vld_reg <= {vld_reg[2:0], in_valid};
      end
   end

   always_ff @(posedge clk) begin
      p_reg <= p_next;
   end

   // Channel 0 is sine; channel 1 is cosine, i.e. sine one quadrant ahead.
   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      fold_t                f;
      logic [QAW-1:0]       addr_reg;
      logic                 neg2_reg;
      logic                 neg3_reg;
      logic signed [DW-1:0] mag;
      logic signed [DW-1:0] res_reg;

      assign f = fold(p_reg[PW-1:PW-2] + 2'(gi));

      always_ff @(posedge clk) begin
         addr_reg <= f.mirror ? ~p_reg[QAW-1:0] : p_reg[QAW-1:0];
         neg2_reg <= f.negate;
         neg3_reg <= neg2_reg;
      end

      assign rom_addr[gi] = addr_reg;
      assign mag          = signed'({1'b0, rom_data[gi]});

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            res_reg <= '0;
         else if (vld_reg[2])
            res_reg <= neg3_reg ? -mag : mag;
      end

      assign res[gi] = res_reg;
   end

   sc_qrom #(
      .AW (QAW),
      .MW (MW)
   ) u_qrom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   assign out_valid = vld_reg[3];
   assign sin       = res[0];
   assign cos       = res[1];

endmodule
